voice_allocator: RTL

- Polyphonic voice scheduler in front of a bank of NVOICE oscillator instances.
- Accepts note-on/note-off events over a valid/ready handshake from the MIDI decoder.
- Assigns each note to a voice and drives that voice's enable and 7-bit frequency index (note-21, 0..87), which addresses the oscillator frequency LUT.
- When all voices are busy, steals the oldest voice.

---
 rtl/voice_allocator_if.sv | 10 +
 rtl/voice_allocator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator_if.sv
// Event handshake between the MIDI decoder (master) and the voice allocator (slave).
interface voice_allocator_if;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_on;
   logic [6:0] ev_note;

   modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
   modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note events to NVOICE oscillators, stealing the oldest voice.
// Optional sustain pedal support is built when VOICE_ALLOC_SUSTAIN_EN is defined.
//
// state  | meaning
// IDLE   | waiting for an event (ev_ready high), range check on accept
// SCAN   | walk voices 0..NVOICE-1 recording match / free / oldest
// COMMIT | apply the note-on / note-off decision to one voice
module voice_allocator #(
   parameter int NVOICE = 4,
   parameter int AW     = 8
) (
   input  logic                clk,
   input  logic                reset,
`ifdef VOICE_ALLOC_SUSTAIN_EN
   input  logic                sustain,
`endif
   voice_allocator_if.slave    ev,
   output logic [NVOICE-1:0]   voice_en,
   output logic [7*NVOICE-1:0] voice_freq,
   output logic                steal,
   output logic                drop
);

   localparam int IW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NVOICE - 1);
   localparam logic [AW-1:0] AGE_MAX = {AW{1'b1}};
   localparam logic [6:0] NOTE_LO = 7'd21;
   localparam logic [6:0] NOTE_HI = 7'd108;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              on_q, on_d;
   logic [6:0]        note_q, note_d;
   logic [NVOICE-1:0] en_q, en_d;
   logic [6:0]        freq_q [NVOICE];
   logic [6:0]        freq_d [NVOICE];
   logic [6:0]        vnote_q [NVOICE];
   logic [6:0]        vnote_d [NVOICE];
   logic [AW-1:0]     age_q [NVOICE];
   logic [AW-1:0]     age_d [NVOICE];
   logic              m_found_q, m_found_d, f_found_q, f_found_d, o_found_q, o_found_d;
   logic [IW-1:0]     m_idx_q, m_idx_d, f_idx_q, f_idx_d, o_idx_q, o_idx_d;
   logic [AW-1:0]     o_age_q, o_age_d;
   logic              steal_q, steal_d, drop_q, drop_d, rdrop_q, rdrop_d;
   logic [IW-1:0]     tgt;
   logic              rel_now;

`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic [NVOICE-1:0] pend_q, pend_d;
   logic              sus_prev_q, sus_prev_d;
   // Pedal release is only acted on in IDLE; a fall during a scan is picked up on return.
   assign rel_now = (state_q == IDLE) && sus_prev_q && !sustain;
`else
   assign rel_now = 1'b0;
`endif

   assign ev.ev_ready = reset && (state_q == IDLE) && !rel_now;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      on_d      = on_q;
      note_d    = note_q;
      en_d      = en_q;
      freq_d    = freq_q;
      vnote_d   = vnote_q;
      age_d     = age_q;
      m_found_d = m_found_q;
      f_found_d = f_found_q;
      o_found_d = o_found_q;
      m_idx_d   = m_idx_q;
      f_idx_d   = f_idx_q;
      o_idx_d   = o_idx_q;
      o_age_d   = o_age_q;
      steal_d   = 1'b0;
      drop_d    = rdrop_q;
      rdrop_d   = 1'b0;
      tgt       = m_idx_q;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      pend_d     = pend_q;
      sus_prev_d = sus_prev_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
            sus_prev_d = sustain;
            if (rel_now) begin
               en_d   = en_q & ~pend_q;
               pend_d = '0;
            end
`endif
            if (ev.ev_valid && ev.ev_ready) begin
               if (ev.ev_note < NOTE_LO || ev.ev_note > NOTE_HI) begin
                  rdrop_d = 1'b1;
               end else begin
                  state_d   = SCAN;
                  idx_d     = '0;
                  on_d      = ev.ev_on;
                  note_d    = ev.ev_note;
                  m_found_d = 1'b0;
                  f_found_d = 1'b0;
                  o_found_d = 1'b0;
               end
            end
         end
         SCAN: begin
            if (en_q[idx_q]) begin
               if (vnote_q[idx_q] == note_q) begin
                  m_found_d = 1'b1;
                  m_idx_d   = idx_q;
               end
               // Strict compare keeps the lowest index on equal ages.
               if (!o_found_q || age_q[idx_q] > o_age_q) begin
                  o_found_d = 1'b1;
                  o_idx_d   = idx_q;
                  o_age_d   = age_q[idx_q];
               end
            end else if (!f_found_q) begin
               f_found_d = 1'b1;
               f_idx_d   = idx_q;
            end
            if (idx_q == LAST) state_d = COMMIT;
            else               idx_d   = idx_q + 1'b1;
         end
         COMMIT: begin
            state_d = IDLE;
            if (on_q) begin
               tgt = m_found_q ? m_idx_q : (f_found_q ? f_idx_q : o_idx_q);
               for (int j = 0; j < NVOICE; j++) begin
                  if (en_q[j] && IW'(j) != tgt && age_q[j] != AGE_MAX)
                     age_d[j] = age_q[j] + 1'b1;
               end
               age_d[tgt] = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
               pend_d[tgt] = 1'b0;
`endif
               if (!m_found_q) begin
                  en_d[tgt]    = 1'b1;
                  freq_d[tgt]  = note_q - NOTE_LO;
                  vnote_d[tgt] = note_q;
                  steal_d      = !f_found_q;
               end
            end else if (m_found_q) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
               if (sustain) begin
                  pend_d[m_idx_q] = 1'b1;
               end else begin
                  en_d[m_idx_q]  = 1'b0;
                  age_d[m_idx_q] = '0;
               end
`else
               en_d[m_idx_q]  = 1'b0;
               age_d[m_idx_q] = '0;
`endif
            end else begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         on_q      <= 1'b0;
         note_q    <= '0;
         en_q      <= '0;
         m_found_q <= 1'b0;
         f_found_q <= 1'b0;
         o_found_q <= 1'b0;
         m_idx_q   <= '0;
         f_idx_q   <= '0;
         o_idx_q   <= '0;
         o_age_q   <= '0;
         steal_q   <= 1'b0;
         drop_q    <= 1'b0;
         rdrop_q   <= 1'b0;
         for (int i = 0; i < NVOICE; i++) begin
            freq_q[i]  <= '0;
            vnote_q[i] <= '0;
            age_q[i]   <= '0;
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         pend_q     <= '0;
         sus_prev_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         on_q      <= on_d;
         note_q    <= note_d;
         en_q      <= en_d;
         m_found_q <= m_found_d;
         f_found_q <= f_found_d;
         o_found_q <= o_found_d;
         m_idx_q   <= m_idx_d;
         f_idx_q   <= f_idx_d;
         o_idx_q   <= o_idx_d;
         o_age_q   <= o_age_d;
         steal_q   <= steal_d;
         drop_q    <= drop_d;
         rdrop_q   <= rdrop_d;
         for (int i = 0; i < NVOICE; i++) begin
            freq_q[i]  <= freq_d[i];
            vnote_q[i] <= vnote_d[i];
            age_q[i]   <= age_d[i];
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         pend_q     <= pend_d;
         sus_prev_q <= sus_prev_d;
`endif
      end
   end

   always_comb begin
      voice_freq = '0;
      for (int i = 0; i < NVOICE; i++) voice_freq[7*i +: 7] = freq_q[i];
   end

   assign voice_en = en_q;
   assign steal    = steal_q;
   assign drop     = drop_q;

endmodule
